// File: rtl/z80_int_daisy_pkg.sv
// Shared Z80 bus definitions for the PIO interrupt daisy-chain slice:
// opcode bytes snooped on the data bus, the controller state encoding,
// and small helpers that decode Z80 bus cycle types from the strobes.
package z80_bus_pkg;

    // Opcode bytes of the ED-prefixed return instructions
    localparam logic [7:0] OP_ED   = 8'hED;
    localparam logic [7:0] OP_RETI = 8'h4D;
    localparam logic [7:0] OP_RETN = 8'h45;

    // Daisy-chain controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_SERV = 2'd3
    } daisy_state_t;

    // Interrupt acknowledge cycle: M1 and IORQ low together
    function automatic logic is_inta(input logic m1_n, input logic iorq_n);
        return ~m1_n & ~iorq_n;
    endfunction

    // Opcode fetch cycle: M1 and RD low, IORQ high
    function automatic logic is_fetch(input logic m1_n, input logic rd_n,
                                      input logic iorq_n);
        return ~m1_n & ~rd_n & iorq_n;
    endfunction

endpackage

// File: rtl/z80_reti_detect.sv
// RETI snooper: watches opcode fetches on the CPU data bus and flags the
// two-byte ED 4D sequence. Every fetch is counted once, however many
// clock-enabled cycles M1 stays low, so long fetches are not re-decoded.
module z80_reti_detect
    import z80_bus_pkg::*;
#(
    parameter logic [7:0] PREFIX  = OP_ED,
    parameter logic [7:0] RETI_OP = OP_RETI
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ena,
    input  logic       i_m1_n,
    input  logic       i_rd_n,
    input  logic       i_iorq_n,
    input  logic [7:0] i_di,
    output logic       o_ed_seen,
    output logic       o_reti_pulse
);

    logic r_ed_seen;
    logic r_fetch_done;
    logic w_new_fetch;

    // A fetch is new only if it has not already been counted in this M1
    always_comb begin
        w_new_fetch = is_fetch(i_m1_n, i_rd_n, i_iorq_n) & ~r_fetch_done;
    end

    // Track the prefix byte and whether the current M1 was already counted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ed_seen    <= 1'b0;
            r_fetch_done <= 1'b0;
        end else if (i_ena) begin
            if (i_m1_n) begin
                r_fetch_done <= 1'b0;
            end else if (w_new_fetch) begin
                r_fetch_done <= 1'b1;
            end
            if (w_new_fetch) begin
                r_ed_seen <= (i_di == PREFIX);
            end
        end
    end

    assign o_ed_seen    = r_ed_seen;
    assign o_reti_pulse = i_ena & w_new_fetch & r_ed_seen & (i_di == RETI_OP);

endmodule

// File: rtl/z80_int_daisy.sv
// Z80 mode-2 interrupt daisy-chain controller for the PIO port block.
// Turns the port's masked interrupt condition into INT_n, arbitrates with
// the IEI/IEO chain, puts the port vector on the bus during INTA, and
// leaves in-service when the CPU executes RETI for this device.
module z80_int_daisy
    import z80_bus_pkg::*;
#(
    parameter bit         EDGE    = 1'b1,
    parameter logic [7:0] PREFIX  = OP_ED,
    parameter logic [7:0] RETI_OP = OP_RETI
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ena,
    input  logic       i_m1_n,
    input  logic       i_iorq_n,
    input  logic       i_rd_n,
    input  logic [7:0] i_di,
    input  logic       i_iei,
    input  logic       i_inti,
    input  logic       i_inten,
    input  logic [7:0] i_vect,
    output logic       o_int_n,
    output logic       o_ieo,
    output logic       o_vecten,
    output logic [7:0] o_do
);

    daisy_state_t r_state;
    daisy_state_t w_state_next;
    logic         r_ip;
    logic         w_ip_next;
    logic         r_ius;
    logic         w_ius_next;
    logic         r_inti_hist;
    logic         r_int_n;
    logic         w_int_n_next;
    logic         w_inti_rise;
    logic         w_serv_entry;
    logic         w_ed_seen;
    logic         w_reti;

    z80_reti_detect #(
        .PREFIX  (PREFIX),
        .RETI_OP (RETI_OP)
    ) u_reti_detect (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ena        (i_ena),
        .i_m1_n       (i_m1_n),
        .i_rd_n       (i_rd_n),
        .i_iorq_n     (i_iorq_n),
        .i_di         (i_di),
        .o_ed_seen    (w_ed_seen),
        .o_reti_pulse (w_reti)
    );

    // Next pending flag: mask off wins, a new event beats the clear on SERV entry
    always_comb begin
        w_inti_rise  = i_inti & ~r_inti_hist;
        w_serv_entry = (r_state == ST_ACK) & i_iorq_n;
        if (!i_inten) begin
            w_ip_next = 1'b0;
        end else if (EDGE) begin
            if (w_inti_rise) begin
                w_ip_next = 1'b1;
            end else if (w_serv_entry) begin
                w_ip_next = 1'b0;
            end else begin
                w_ip_next = r_ip;
            end
        end else begin
            w_ip_next = i_inti & ~w_serv_entry;
        end
    end

    // Next state, in-service flag and registered INT_n value
    always_comb begin
        w_state_next = r_state;
        w_ius_next   = r_ius;
        case (r_state)
            ST_IDLE: begin
                if (w_ip_next) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (is_inta(i_m1_n, i_iorq_n) && i_iei) begin
                    w_state_next = ST_ACK;
                end else if (!w_ip_next) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (i_iorq_n) begin
                    w_state_next = ST_SERV;
                    w_ius_next   = 1'b1;
                end
            end
            ST_SERV: begin
                if (w_reti && i_iei) begin
                    w_ius_next   = 1'b0;
                    w_state_next = w_ip_next ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_int_n_next = ~((w_state_next == ST_REQ) & i_iei);
    end

    // Controller registers, advanced only on CPU clock-enable cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ip        <= 1'b0;
            r_ius       <= 1'b0;
            r_inti_hist <= 1'b0;
            r_int_n     <= 1'b1;
        end else if (i_ena) begin
            r_state     <= w_state_next;
            r_ip        <= w_ip_next;
            r_ius       <= w_ius_next;
            r_inti_hist <= i_inti;
            r_int_n     <= w_int_n_next;
        end
    end

    // Hold lower devices off while pending or in service, but let the chain
    // open between ED and 4D so a lower device can see its own RETI
    always_comb begin
        o_ieo = i_iei & ~r_ius & ~(r_ip & ~w_ed_seen) & (r_state != ST_ACK);
    end

    // Vector drive only while this device owns the acknowledge cycle
    always_comb begin
        o_vecten = (r_state == ST_ACK);
        o_do     = o_vecten ? i_vect : 8'h00;
    end

    assign o_int_n = r_int_n;

endmodule

// File: tb/tb_z80_int_daisy.sv
// Bench for the daisy-chain controller: directed scenarios with literal
// expectations, then randomized bus traffic, all compared every cycle
// against an event-level model of pending / requesting / vectoring /
// in-service behaviour.
module tb_z80_int_daisy;

    localparam int BUS_IDLE  = 0;
    localparam int BUS_INTA  = 1;
    localparam int BUS_FETCH = 2;
    localparam int BUS_IO    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       m1N = 1'b1;
    logic       iorqN = 1'b1;
    logic       rdN = 1'b1;
    logic [7:0] di = 8'h00;
    logic       iei = 1'b1;
    logic       inti = 1'b1;
    logic       inten = 1'b1;
    logic [7:0] vect = 8'h30;
    logic       intN;
    logic       ieo;
    logic       vecten;
    logic [7:0] dout;

    int nTests = 0;
    int nFail = 0;

    // Reference model state
    logic mPending = 1'b0;
    logic mRequesting = 1'b0;
    logic mVectoring = 1'b0;
    logic mInService = 1'b0;
    logic mPrefix = 1'b0;
    logic mFetchCounted = 1'b0;
    logic mLastInti = 1'b0;
    logic mIntN = 1'b1;

    z80_int_daisy dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ena    (ena),
        .i_m1_n   (m1N),
        .i_iorq_n (iorqN),
        .i_rd_n   (rdN),
        .i_di     (di),
        .i_iei    (iei),
        .i_inti   (inti),
        .i_inten  (inten),
        .i_vect   (vect),
        .o_int_n  (intN),
        .o_ieo    (ieo),
        .o_vecten (vecten),
        .o_do     (dout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change one time unit after the falling edge, away from both
    // the sampling rising edge and the compare on the falling edge
    task automatic waitCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int op, input logic [7:0] data);
        case (op)
            BUS_INTA:  begin m1N = 1'b0; iorqN = 1'b0; rdN = 1'b1; end
            BUS_FETCH: begin m1N = 1'b0; iorqN = 1'b1; rdN = 1'b0; end
            BUS_IO:    begin m1N = 1'b1; iorqN = 1'b0; rdN = 1'b0; end
            default:   begin m1N = 1'b1; iorqN = 1'b1; rdN = 1'b1; end
        endcase
        di = data;
    endtask

    // One fetch cycle followed by an M1-high cycle
    task automatic fetchByte(input logic [7:0] data);
        applyStimulus(BUS_FETCH, data);
        waitCycle();
        applyStimulus(BUS_IDLE, 8'h00);
        waitCycle();
    endtask

    // Event-level reference model, advanced on every clock-enabled edge
    always @(posedge clk or posedge rst) begin : refModel
        logic rise, inta, fetchNew, reti, pendNext, nowReq, nowAck, nowServ;
        if (rst) begin
            mPending      <= 1'b0;
            mRequesting   <= 1'b0;
            mVectoring    <= 1'b0;
            mInService    <= 1'b0;
            mPrefix       <= 1'b0;
            mFetchCounted <= 1'b0;
            mLastInti     <= 1'b0;
            mIntN         <= 1'b1;
        end else if (ena) begin
            rise     = inti && !mLastInti;
            inta     = !m1N && !iorqN;
            fetchNew = !m1N && !rdN && iorqN && !mFetchCounted;
            reti     = fetchNew && mPrefix && (di == 8'h4D);
            if (!inten)                      pendNext = 1'b0;
            else if (rise)                   pendNext = 1'b1;
            else if (mVectoring && iorqN)    pendNext = 1'b0;
            else                             pendNext = mPending;
            nowReq  = mRequesting;
            nowAck  = mVectoring;
            nowServ = mInService;
            if (mRequesting) begin
                if (inta && iei) begin
                    nowReq = 1'b0;
                    nowAck = 1'b1;
                end else if (!pendNext) begin
                    nowReq = 1'b0;
                end
            end else if (mVectoring) begin
                if (iorqN) begin
                    nowAck  = 1'b0;
                    nowServ = 1'b1;
                end
            end else if (mInService) begin
                if (reti && iei) begin
                    nowServ = 1'b0;
                    nowReq  = pendNext;
                end
            end else begin
                nowReq = pendNext;
            end
            mPending    <= pendNext;
            mRequesting <= nowReq;
            mVectoring  <= nowAck;
            mInService  <= nowServ;
            mIntN       <= !(nowReq && iei);
            if (fetchNew) mPrefix <= (di == 8'hED);
            if (m1N) mFetchCounted <= 1'b0;
            else if (fetchNew) mFetchCounted <= 1'b1;
            mLastInti <= inti;
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        checkOutput("model_int_n", {7'd0, intN}, {7'd0, mIntN});
        checkOutput("model_vecten", {7'd0, vecten}, {7'd0, mVectoring});
        checkOutput("model_do", dout, mVectoring ? vect : 8'h00);
        checkOutput("model_ieo", {7'd0, ieo},
                    {7'd0, iei && !mInService && !(mPending && !mPrefix) && !mVectoring});
    end

    // Directed scenarios, then randomized traffic
    initial begin
        applyStimulus(BUS_IDLE, 8'h00);
        waitCycle();
        waitCycle();

        // Reset with an active condition upstream
        checkOutput("rst_int_n", {7'd0, intN}, 8'h01);
        checkOutput("rst_vecten", {7'd0, vecten}, 8'h00);
        checkOutput("rst_do", dout, 8'h00);
        checkOutput("rst_ieo", {7'd0, ieo}, 8'h01);
        inti = 1'b0;
        rst = 1'b0;
        waitCycle();
        waitCycle();
        checkOutput("idle_int_n", {7'd0, intN}, 8'h01);

        // Basic request / acknowledge / RETI cycle
        inti = 1'b1;
        waitCycle();
        checkOutput("basic_req_int_n", {7'd0, intN}, 8'h00);
        checkOutput("basic_req_ieo", {7'd0, ieo}, 8'h00);
        applyStimulus(BUS_INTA, 8'h00);
        waitCycle();
        checkOutput("basic_ack_vecten", {7'd0, vecten}, 8'h01);
        checkOutput("basic_ack_do", dout, 8'h30);
        checkOutput("basic_ack_int_n", {7'd0, intN}, 8'h01);
        applyStimulus(BUS_IDLE, 8'h00);
        waitCycle();
        checkOutput("basic_serv_int_n", {7'd0, intN}, 8'h01);
        checkOutput("basic_serv_ieo", {7'd0, ieo}, 8'h00);
        checkOutput("basic_serv_do", dout, 8'h00);
        fetchByte(8'hED);
        fetchByte(8'h4D);
        checkOutput("basic_reti_ieo", {7'd0, ieo}, 8'h01);
        checkOutput("basic_reti_int_n", {7'd0, intN}, 8'h01);

        // Higher-priority device active
        inti = 1'b0;
        waitCycle();
        inti = 1'b1;
        waitCycle();
        checkOutput("prio_req_int_n", {7'd0, intN}, 8'h00);
        iei = 1'b0;
        waitCycle();
        checkOutput("prio_held_int_n", {7'd0, intN}, 8'h01);
        applyStimulus(BUS_INTA, 8'h00);
        waitCycle();
        checkOutput("prio_inta_vecten", {7'd0, vecten}, 8'h00);
        waitCycle();
        checkOutput("prio_inta2_vecten", {7'd0, vecten}, 8'h00);
        applyStimulus(BUS_IDLE, 8'h00);
        iei = 1'b1;
        waitCycle();
        checkOutput("prio_rel_int_n", {7'd0, intN}, 8'h00);
        applyStimulus(BUS_INTA, 8'h00);
        waitCycle();
        checkOutput("prio_ack_do", dout, 8'h30);
        applyStimulus(BUS_IDLE, 8'h00);
        waitCycle();

        // RETI filtering while in service
        fetchByte(8'hED);
        fetchByte(8'h00);
        fetchByte(8'h4D);
        checkOutput("filt_gap_ieo", {7'd0, ieo}, 8'h00);
        iei = 1'b0;
        fetchByte(8'hED);
        fetchByte(8'h4D);
        iei = 1'b1;
        waitCycle();
        checkOutput("filt_iei0_ieo", {7'd0, ieo}, 8'h00);
        fetchByte(8'hED);
        fetchByte(8'h4D);
        checkOutput("filt_ok_ieo", {7'd0, ieo}, 8'h01);

        // Mask off while requesting, then edge re-arm
        inti = 1'b0;
        waitCycle();
        inti = 1'b1;
        waitCycle();
        checkOutput("mask_req_int_n", {7'd0, intN}, 8'h00);
        inten = 1'b0;
        waitCycle();
        checkOutput("mask_off_int_n", {7'd0, intN}, 8'h01);
        checkOutput("mask_off_ieo", {7'd0, ieo}, 8'h01);
        inten = 1'b1;
        for (int i = 0; i < 3; i++) waitCycle();
        checkOutput("mask_held_int_n", {7'd0, intN}, 8'h01);
        inti = 1'b0;
        waitCycle();
        inti = 1'b1;
        waitCycle();
        checkOutput("mask_rearm_int_n", {7'd0, intN}, 8'h00);

        // Mask off in the same cycle as INTA: acknowledge still taken
        inten = 1'b0;
        applyStimulus(BUS_INTA, 8'h00);
        waitCycle();
        checkOutput("race_vecten", {7'd0, vecten}, 8'h01);
        inten = 1'b1;
        applyStimulus(BUS_IDLE, 8'h00);
        waitCycle();
        checkOutput("race_serv_ieo", {7'd0, ieo}, 8'h00);
        fetchByte(8'hED);
        fetchByte(8'h4D);

        // Asynchronous reset while requesting and while acknowledged
        inti = 1'b0;
        waitCycle();
        inti = 1'b1;
        waitCycle();
        checkOutput("arst_req_int_n", {7'd0, intN}, 8'h00);
        #1 rst = 1'b1;
        #1 checkOutput("arst_req_rel_int_n", {7'd0, intN}, 8'h01);
        inti = 1'b0;
        waitCycle();
        rst = 1'b0;
        waitCycle();
        inti = 1'b1;
        waitCycle();
        applyStimulus(BUS_INTA, 8'h00);
        waitCycle();
        checkOutput("arst_ack_vecten", {7'd0, vecten}, 8'h01);
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_ack_vecten_rel", {7'd0, vecten}, 8'h00);
        checkOutput("arst_ack_do", dout, 8'h00);
        checkOutput("arst_ack_int_n", {7'd0, intN}, 8'h01);
        inti = 1'b0;
        applyStimulus(BUS_IDLE, 8'h00);
        waitCycle();
        rst = 1'b0;
        waitCycle();
        checkOutput("arst_after_ieo", {7'd0, ieo}, 8'h01);

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            ena   = ($urandom % 8) != 0;
            iei   = ($urandom % 8) != 0;
            inten = ($urandom % 16) != 0;
            if (($urandom % 6) == 0) inti = ~inti;
            vect  = 8'($urandom);
            rst   = ($urandom % 1000) == 0;
            if (($urandom % 2) == 0) begin
                int k;
                int sel;
                logic [7:0] d;
                k   = int'($urandom % 10);
                sel = int'($urandom % 4);
                d   = (sel == 0) ? 8'hED : (sel == 1) ? 8'h4D :
                      (sel == 2) ? 8'h00 : 8'($urandom);
                if (k < 4)       applyStimulus(BUS_IDLE, d);
                else if (k == 4) applyStimulus(BUS_IO, d);
                else if (k < 7)  applyStimulus(BUS_INTA, d);
                else             applyStimulus(BUS_FETCH, d);
            end
            waitCycle();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
